// File: rtl/vtracer_pkg.sv
// ----------------------------------------------------------------------------
// vtracer_pkg
// Shared definitions for the sphere ray-tracer frame sequencer: bus widths,
// the packing of the ray-direction word, the "no hit" tracer value and the
// scheduler FSM state codes.
// Ports: none (package).
// ----------------------------------------------------------------------------
package vtracer_pkg;

    localparam int INIT_W = 28;
    localparam int DIR_W  = 31;
    localparam int OBJ_W  = 48;
    localparam int T_W    = 10;

    // Ray-direction word layout: {dx, dy, dz}
    localparam int DX_MSB = 30;
    localparam int DX_LSB = 20;
    localparam int DY_MSB = 19;
    localparam int DY_LSB = 9;
    localparam int DZ_MSB = 8;
    localparam int DZ_LSB = 0;

    localparam logic [T_W-1:0] T_MISS = 10'h3FF;

    // Scheduler FSM state codes
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_CMP   = 3'd3;
    localparam state_t ST_EMIT  = 3'd4;

    // Assemble a ray-direction word from its signed dx/dy and unsigned dz fields
    function automatic logic [DIR_W-1:0] pack_dir(input logic [10:0] dx,
                                                  input logic [10:0] dy,
                                                  input logic [8:0]  dz);
        logic [DIR_W-1:0] d;
        d                = {DIR_W{1'b0}};
        d[DX_MSB:DX_LSB] = dx;
        d[DY_MSB:DY_LSB] = dy;
        d[DZ_MSB:DZ_LSB] = dz;
        return d;
    endfunction

endpackage

// File: rtl/nearest_hit_reg.sv
// ----------------------------------------------------------------------------
// nearest_hit_reg
// Tracks the nearest hit seen so far for the current pixel.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clr           restart tracking (best_t=T_MISS, best_obj=0, hit=0)
//   upd           compare t_in/obj_in against the current best this cycle
//   t_in, obj_in  candidate distance and object index
//   best_t, best_obj, hit   current nearest result (registered)
// ----------------------------------------------------------------------------
module nearest_hit_reg
    import vtracer_pkg::*;
#(
    parameter int             OBJ_AW = 3,
    parameter logic [T_W-1:0] T_MISS = vtracer_pkg::T_MISS
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              upd,
    input  logic [T_W-1:0]    t_in,
    input  logic [OBJ_AW-1:0] obj_in,
    output logic [T_W-1:0]    best_t,
    output logic [OBJ_AW-1:0] best_obj,
    output logic              hit
);

    logic [T_W-1:0]    best_t_r;
    logic [OBJ_AW-1:0] best_obj_r;
    logic              hit_r;
    logic              take_s;

    // Strict less-than keeps the earlier (lower-index) object on equal distance
    always_comb begin
        take_s = 1'b0;
        if (upd && (t_in != T_MISS) && (!hit_r || (t_in < best_t_r))) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // Best-so-far storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_t_r   <= T_MISS;
            best_obj_r <= {OBJ_AW{1'b0}};
            hit_r      <= 1'b0;
        end else if (clr) begin
            best_t_r   <= T_MISS;
            best_obj_r <= {OBJ_AW{1'b0}};
            hit_r      <= 1'b0;
        end else if (take_s) begin
            best_t_r   <= t_in;
            best_obj_r <= obj_in;
            hit_r      <= 1'b1;
        end
    end

    assign best_t   = best_t_r;
    assign best_obj = best_obj_r;
    assign hit      = hit_r;

endmodule

// File: rtl/sphere_scan_scheduler.sv
// ----------------------------------------------------------------------------
// sphere_scan_scheduler
// Walks every pixel of a frame, issues one ray per loaded object to the shared
// sphere tracer, keeps the nearest hit and emits one result per pixel.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, cam_init, obj_count  frame start with ray origin and object count
//   obj_we/obj_waddr/obj_wdata  object table write port (ignored while busy)
//   tr_init, tr_dir, tr_object  registered tracer inputs
//   tr_t                      tracer distance result
//   px_valid/px_ready         result handshake
//   px_x, px_y, px_t, px_obj, px_hit  result payload
//   busy, frame_done          status (frame_done is a one-cycle pulse)
// ----------------------------------------------------------------------------
module sphere_scan_scheduler
    import vtracer_pkg::*;
#(
    parameter int             H_RES     = 64,
    parameter int             V_RES     = 48,
    parameter logic [8:0]     FOCAL     = 9'd256,
    parameter int             OBJ_AW    = 3,
    parameter int             TRACE_LAT = 4,
    parameter logic [T_W-1:0] T_MISS    = vtracer_pkg::T_MISS
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [INIT_W-1:0]   cam_init,
    input  logic [OBJ_AW:0]     obj_count,
    input  logic                obj_we,
    input  logic [OBJ_AW-1:0]   obj_waddr,
    input  logic [OBJ_W-1:0]    obj_wdata,
    output logic [INIT_W-1:0]   tr_init,
    output logic [DIR_W-1:0]    tr_dir,
    output logic [OBJ_W-1:0]    tr_object,
    input  logic [T_W-1:0]      tr_t,
    output logic                px_valid,
    input  logic                px_ready,
    output logic [9:0]          px_x,
    output logic [9:0]          px_y,
    output logic [T_W-1:0]      px_t,
    output logic [OBJ_AW-1:0]   px_obj,
    output logic                px_hit,
    output logic                busy,
    output logic                frame_done
);

    localparam int              WCW       = (TRACE_LAT > 1) ? $clog2(TRACE_LAT) : 1;
    localparam logic [WCW-1:0]  WAIT_LOAD = WCW'(TRACE_LAT - 1);
    localparam logic [9:0]      X_LAST    = 10'(H_RES - 1);
    localparam logic [9:0]      Y_LAST    = 10'(V_RES - 1);
    localparam logic [10:0]     X_HALF    = 11'(H_RES / 2);
    localparam logic [10:0]     Y_HALF    = 11'(V_RES / 2);

    logic [OBJ_W-1:0]  obj_tab_r [2**OBJ_AW];
    state_t            state_r;
    logic [9:0]        x_r;
    logic [9:0]        y_r;
    logic [OBJ_AW-1:0] k_r;
    logic [OBJ_AW:0]   cnt_r;
    logic [WCW-1:0]    wait_r;
    logic              busy_r;
    logic              done_r;
    logic              valid_r;
    logic [INIT_W-1:0] tr_init_r;
    logic [DIR_W-1:0]  tr_dir_r;
    logic [OBJ_W-1:0]  tr_object_r;

    logic [10:0]       dx_s;
    logic [10:0]       dy_s;
    logic [OBJ_AW:0]   k_next_s;
    logic              more_obj_s;
    logic              accept_s;
    logic              last_px_s;
    logic              start_ok_s;
    logic              hit_clr_s;
    logic              hit_upd_s;

    // Pixel-to-ray geometry, object loop control and handshake decode
    always_comb begin
        dx_s       = {1'b0, x_r} - X_HALF;
        dy_s       = Y_HALF - {1'b0, y_r};
        k_next_s   = {1'b0, k_r} + {{OBJ_AW{1'b0}}, 1'b1};
        more_obj_s = (k_next_s < cnt_r);
        accept_s   = valid_r && px_ready;
        last_px_s  = (x_r == X_LAST) && (y_r == Y_LAST);
        // frame_done is still high on the first IDLE cycle; a start there is dropped
        start_ok_s = (state_r == ST_IDLE) && start && !done_r;
        hit_clr_s  = start_ok_s || ((state_r == ST_EMIT) && accept_s);
        hit_upd_s  = (state_r == ST_CMP);
    end

    nearest_hit_reg #(
        .OBJ_AW (OBJ_AW),
        .T_MISS (T_MISS)
    ) u_nearest (
        .clk      (clk),
        .rst      (rst),
        .clr      (hit_clr_s),
        .upd      (hit_upd_s),
        .t_in     (tr_t),
        .obj_in   (k_r),
        .best_t   (px_t),
        .best_obj (px_obj),
        .hit      (px_hit)
    );

    // Object table: loadable only between frames, deliberately not reset
    always_ff @(posedge clk) begin
        if (obj_we && !busy_r) begin
            obj_tab_r[obj_waddr] <= obj_wdata;
        end
    end

    // Frame sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            x_r         <= 10'd0;
            y_r         <= 10'd0;
            k_r         <= {OBJ_AW{1'b0}};
            cnt_r       <= {(OBJ_AW+1){1'b0}};
            wait_r      <= {WCW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            valid_r     <= 1'b0;
            tr_init_r   <= {INIT_W{1'b0}};
            tr_dir_r    <= {DIR_W{1'b0}};
            tr_object_r <= {OBJ_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        tr_init_r <= cam_init;
                        cnt_r     <= obj_count;
                        x_r       <= 10'd0;
                        y_r       <= 10'd0;
                        k_r       <= {OBJ_AW{1'b0}};
                        busy_r    <= 1'b1;
                        // With no objects every pixel is an immediate miss
                        if (obj_count == {(OBJ_AW+1){1'b0}}) begin
                            state_r <= ST_EMIT;
                            valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    tr_dir_r    <= pack_dir(dx_s, dy_s, FOCAL);
                    tr_object_r <= obj_tab_r[k_r];
                    wait_r      <= WAIT_LOAD;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_r == {WCW{1'b0}}) begin
                        state_r <= ST_CMP;
                    end else begin
                        wait_r <= wait_r - WCW'(1);
                    end
                end
                ST_CMP: begin
                    if (more_obj_s) begin
                        k_r     <= k_next_s[OBJ_AW-1:0];
                        state_r <= ST_ISSUE;
                    end else begin
                        valid_r <= 1'b1;
                        state_r <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (accept_s) begin
                        k_r <= {OBJ_AW{1'b0}};
                        if (last_px_s) begin
                            x_r     <= 10'd0;
                            y_r     <= 10'd0;
                            valid_r <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            if (x_r == X_LAST) begin
                                x_r <= 10'd0;
                                y_r <= y_r + 10'd1;
                            end else begin
                                x_r <= x_r + 10'd1;
                            end
                            // Zero-object frames stay in EMIT with valid held high
                            if (cnt_r == {(OBJ_AW+1){1'b0}}) begin
                                valid_r <= 1'b1;
                                state_r <= ST_EMIT;
                            end else begin
                                valid_r <= 1'b0;
                                state_r <= ST_ISSUE;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tr_init    = tr_init_r;
    assign tr_dir     = tr_dir_r;
    assign tr_object  = tr_object_r;
    assign px_valid   = valid_r;
    assign px_x       = x_r;
    assign px_y       = y_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_sphere_scan_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sphere_scan_scheduler
// Self-checking bench: a latency-accurate tracer model feeds the scheduler,
// and every emitted pixel is compared with a frame-level reference computed
// from the object table the bench itself loaded.
// ----------------------------------------------------------------------------
module tb_sphere_scan_scheduler;

    localparam int         H     = 6;
    localparam int         V     = 4;
    localparam int         AW    = 2;
    localparam int         DEPTH = 4;
    localparam int         TL    = 4;
    localparam logic [8:0] FOC   = 9'd256;
    localparam logic [9:0] MISS  = 10'h3FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [27:0] cam_init;
    logic [2:0]  obj_count;
    logic        obj_we;
    logic [1:0]  obj_waddr;
    logic [47:0] obj_wdata;
    logic [27:0] tr_init;
    logic [30:0] tr_dir;
    logic [47:0] tr_object;
    logic [9:0]  tr_t;
    logic        px_valid;
    logic        px_ready;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic [9:0]  px_t;
    logic [1:0]  px_obj;
    logic        px_hit;
    logic        busy;
    logic        frame_done;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [47:0] tab [DEPTH];
    logic [9:0]  pipe [TL];

    sphere_scan_scheduler #(
        .H_RES(H), .V_RES(V), .FOCAL(FOC), .OBJ_AW(AW), .TRACE_LAT(TL), .T_MISS(MISS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cam_init(cam_init), .obj_count(obj_count),
        .obj_we(obj_we), .obj_waddr(obj_waddr), .obj_wdata(obj_wdata),
        .tr_init(tr_init), .tr_dir(tr_dir), .tr_object(tr_object), .tr_t(tr_t),
        .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
        .px_t(px_t), .px_obj(px_obj), .px_hit(px_hit), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tracer behaviour: bit47 = miss, bit46 = distance also depends on low dx bits
    function automatic logic [9:0] trace_f(input logic [47:0] obj, input logic [30:0] dir);
        logic [9:0] v;
        if (obj[47]) return MISS;
        v = obj[9:0];
        if (obj[46]) v = v + {5'd0, dir[24:20]};
        if (v == MISS) v = 10'h3FE;
        return v;
    endfunction

    // Tracer latency: result appears TL cycles after its inputs change
    always @(posedge clk) begin
        pipe[0] <= trace_f(tr_object, tr_dir);
        for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
    end
    assign tr_t = pipe[TL-1];

    function automatic logic [30:0] exp_dir(input int x, input int y);
        int          dxi;
        int          dyi;
        logic [31:0] dxv;
        logic [31:0] dyv;
        dxi = x - H / 2;
        dyi = V / 2 - y;
        dxv = dxi;
        dyv = dyi;
        return {dxv[10:0], dyv[10:0], FOC};
    endfunction

    // Reference: nearest non-miss distance, lowest object index among equals
    task automatic model_px(input int x, input int y, input int cnt,
                            output logic [9:0] t, output logic [1:0] o, output logic h);
        int best;
        logic [9:0] tk;
        best = 1024;
        o = 2'd0;
        for (int k = 0; k < cnt; k++) begin
            tk = trace_f(tab[k], exp_dir(x, y));
            if (tk != MISS && int'(tk) < best) best = int'(tk);
        end
        h = (best < 1024);
        t = h ? 10'(best) : MISS;
        if (h) begin
            for (int k = cnt - 1; k >= 0; k--) begin
                if (int'(trace_f(tab[k], exp_dir(x, y))) == best) o = 2'(k);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic write_obj(input int a, input logic [47:0] d);
        obj_we    = 1'b1;
        obj_waddr = 2'(a);
        obj_wdata = d;
        @(posedge clk); #1;
        obj_we = 1'b0;
        tab[a] = d;
    endtask

    task automatic rand_table();
        logic [47:0] d;
        for (int k = 0; k < DEPTH; k++) begin
            d = {16'($urandom), $urandom};
            d[47] = ($urandom_range(0, 3) == 0);
            d[9:0] = 10'($urandom_range(0, 15) * 4);
            write_obj(k, d);
        end
    endtask

    // One full frame; starts and ends #1 after a rising edge
    task automatic run_frame(input int cnt, input int ready_pct, input bit stall, input bit timing);
        logic [27:0] cam;
        logic [63:0] held;
        logic [9:0]  et;
        logic [1:0]  eo;
        logic        eh;
        int p, n, start_cyc, last_cyc, budget, stall_cnt, ex, ey;
        bit seen;
        cam = 28'($urandom);
        p = 0; n = H * V; budget = 0; stall_cnt = 0; seen = 1'b0; last_cyc = 0; held = 64'd0;
        start = 1'b1; cam_init = cam; obj_count = 3'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        check_val("busy_after_start", 64'(busy), 64'd1);
        while (p < n && budget < 6000) begin
            obj_we    = ($urandom_range(0, 9) == 0);
            obj_waddr = 2'($urandom_range(0, 3));
            obj_wdata = {16'($urandom), $urandom};
            start     = ($urandom_range(0, 15) == 0);
            obj_count = 3'($urandom_range(0, 4));
            check_val("no_early_done", 64'(frame_done), 64'd0);
            if (seen) begin
                check_val("valid_hold", 64'(px_valid), 64'd1);
                check_val("payload_hold", {px_x, px_y, px_t, px_obj, px_hit, tr_dir}, held);
            end else if (px_valid) begin
                seen = 1'b1;
                ex = p % H;
                ey = p / H;
                model_px(ex, ey, cnt, et, eo, eh);
                check_val("px_x", 64'(px_x), 64'(ex));
                check_val("px_y", 64'(px_y), 64'(ey));
                check_val("px_t", 64'(px_t), 64'(et));
                check_val("px_obj", 64'(px_obj), 64'(eo));
                check_val("px_hit", 64'(px_hit), 64'(eh));
                check_val("tr_init", 64'(tr_init), 64'(cam));
                if (cnt > 0) begin
                    check_val("tr_dir", 64'(tr_dir), 64'(exp_dir(ex, ey)));
                    check_val("tr_object", 64'(tr_object), 64'(tab[cnt-1]));
                end
                if (timing) begin
                    if (p == 0) check_val("first_latency", 64'(cyc - start_cyc), 64'(cnt * (TL + 2)));
                    else        check_val("pixel_period", 64'(cyc - last_cyc), 64'(cnt * (TL + 2) + 1));
                end
                last_cyc = cyc;
                held = {px_x, px_y, px_t, px_obj, px_hit, tr_dir};
                if (stall && p == 0) stall_cnt = 10;
            end
            if (px_valid) begin
                px_ready = (stall_cnt > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
                if (stall_cnt > 0) stall_cnt--;
                if (px_ready) begin
                    p++;
                    seen = 1'b0;
                end
            end else begin
                px_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            budget++;
        end
        obj_we = 1'b0; start = 1'b0; px_ready = 1'b0;
        check_val("frame_pixels", 64'(p), 64'(n));
        check_val("frame_done_pulse", 64'(frame_done), 64'd1);
        check_val("busy_clear", 64'(busy), 64'd0);
        check_val("valid_clear", 64'(px_valid), 64'd0);
        // start coinciding with frame_done must be ignored
        start = 1'b1; obj_count = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("done_one_cycle", 64'(frame_done), 64'd0);
        check_val("start_on_done_ignored", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_ctl"}, {busy, frame_done, px_valid, px_hit}, 64'd0);
        check_val({tag, "_px"}, {px_x, px_y, px_obj, px_t}, {22'd0, MISS});
        check_val({tag, "_tr"}, {tr_init, tr_dir}, 64'd0);
        check_val({tag, "_obj"}, 64'(tr_object), 64'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; cam_init = 28'd0; obj_count = 3'd0;
        obj_we = 1'b0; obj_waddr = 2'd0; obj_wdata = 48'd0; px_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // nearest of 40/25 -> object 1
        write_obj(0, 48'd40);
        write_obj(1, 48'd25);
        run_frame(2, 100, 1'b0, 1'b1);

        // all objects miss
        for (int k = 0; k < DEPTH; k++) write_obj(k, 48'h8000_0000_0000);
        run_frame(3, 100, 1'b0, 1'b1);

        // equal distances -> lower index, with a long consumer stall
        write_obj(0, 48'd30);
        write_obj(1, 48'd30);
        run_frame(2, 70, 1'b1, 1'b0);

        // no objects loaded for the frame
        run_frame(0, 100, 1'b0, 1'b1);
        run_frame(0, 50, 1'b0, 1'b0);

        // randomized tables, counts and back-pressure
        for (int r = 0; r < 6; r++) begin
            rand_table();
            run_frame(int'($urandom_range(1, 4)), int'($urandom_range(30, 100)), 1'b0, 1'b0);
        end
        rand_table();
        run_frame(4, 100, 1'b0, 1'b1);

        // reset asserted while waiting on the tracer
        start = 1'b1; cam_init = 28'hABCDEF1; obj_count = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_state("async_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("idle_after_reset", 64'(busy), 64'd0);
        run_frame(2, 100, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
